// File: rtl/prog_fsm_pkg.sv
// Shared definitions for the table-driven FSM: the default widths of the
// legacy a/b sequencer configuration, the entry layout and address packing.
package prog_fsm_pkg;

  localparam int DEF_IN_W    = 2;
  localparam int DEF_STATE_W = 3;
  localparam int DEF_OUT_W   = 1;

  localparam int ADDR_W  = DEF_STATE_W + DEF_IN_W;
  localparam int ENTRY_W = DEF_STATE_W + DEF_OUT_W + 1;

  // One table entry, packed as {hold, next, out}.
  typedef struct packed {
    logic                   hold;
    logic [DEF_STATE_W-1:0] next;
    logic [DEF_OUT_W-1:0]   out;
  } entry_t;

  // Idle entry: hold the output and stay in (or return to) state 0.
  localparam entry_t DEFAULT_ENTRY = '{hold: 1'b1, next: '0, out: '0};

  // Table address of the entry for a {state, in} pair.
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [DEF_STATE_W-1:0] s,
                                                  input logic [DEF_IN_W-1:0]    i);
    return {s, i};
  endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// Transition/output table: flop array with a validated write port, a
// combinational lookup port for the stepping logic and a registered readback.
module prog_fsm_table
  import prog_fsm_pkg::*;
#(
  parameter  int IN_W       = DEF_IN_W,
  parameter  int STATE_W    = DEF_STATE_W,
  parameter  int OUT_W      = DEF_OUT_W,
  parameter  int NUM_STATES = 4,
  parameter  int RST_STATE  = 0,
  localparam int A_W        = STATE_W + IN_W,
  localparam int E_W        = STATE_W + OUT_W + 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               we,
  input  logic [A_W-1:0]     waddr,
  input  logic [STATE_W-1:0] wnext,
  input  logic [OUT_W-1:0]   wout,
  input  logic               whold,
  input  logic [A_W-1:0]     laddr,
  output logic [E_W-1:0]     lentry,
  input  logic [A_W-1:0]     raddr,
  output logic [E_W-1:0]     rdata,
  output logic               wrej
);

  localparam int DEPTH = 1 << A_W;
  localparam logic [E_W-1:0] DEF_ENTRY = {1'b1, STATE_W'(RST_STATE), {OUT_W{1'b0}}};

  logic [E_W-1:0]     mem [DEPTH];
  logic [STATE_W-1:0] wstate;
  logic               wok;

  // A write must name a legal source state and a legal destination state.
  assign wstate = waddr[A_W-1:IN_W];
  assign wok    = (int'(wstate) < NUM_STATES) && (int'(wnext) < NUM_STATES);
  assign wrej   = we & ~wok;

  // Lookup for the current {state, in}; sees the entry before any same-cycle write.
  assign lentry = mem[laddr];

  // Table storage, validated write and registered readback.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: the table is flop-based and deliberately reset, so an unprogrammed machine idles; a RAM-style array would not allow this loop.
      for (int i = 0; i < DEPTH; i++) mem[i] <= DEF_ENTRY;
      rdata <= '0;
    end else begin
      // NOTE: non-blocking assignments make readback and lookup see the pre-write entry in a same-cycle write.
      rdata <= mem[raddr];
      if (we && wok) mem[waddr] <= {whold, wnext, wout};
    end
  end

endmodule

// File: rtl/prog_fsm.sv
// Programmable FSM: state and registered output step through a run-time
// loaded table; cfg_err records any rejected table write until reset.
module prog_fsm
  import prog_fsm_pkg::*;
#(
  parameter  int                IN_W       = DEF_IN_W,
  parameter  int                STATE_W    = DEF_STATE_W,
  parameter  int                OUT_W      = DEF_OUT_W,
  parameter  int                NUM_STATES = 4,
  parameter  int                RST_STATE  = 0,
  parameter  logic [OUT_W-1:0]  RST_OUT    = '0,
  localparam int                A_W        = STATE_W + IN_W,
  localparam int                E_W        = STATE_W + OUT_W + 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               en,
  input  logic [IN_W-1:0]    in,
  output logic [OUT_W-1:0]   y,
  output logic [STATE_W-1:0] state,
  output logic               changed,
  input  logic               cfg_we,
  input  logic [A_W-1:0]     cfg_addr,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  input  logic               cfg_hold,
  input  logic [A_W-1:0]     cfg_raddr,
  output logic [E_W-1:0]     cfg_rdata,
  output logic               cfg_err
);

  typedef struct packed {
    logic               hold;
    logic [STATE_W-1:0] next;
    logic [OUT_W-1:0]   out;
  } ent_t;

  logic [E_W-1:0] lentry;
  ent_t           e;
  logic           wrej;

  prog_fsm_table #(
    .IN_W      (IN_W),
    .STATE_W   (STATE_W),
    .OUT_W     (OUT_W),
    .NUM_STATES(NUM_STATES),
    .RST_STATE (RST_STATE)
  ) u_table (
    .Clk   (Clk),
    .Rst   (Rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wnext (cfg_next),
    .wout  (cfg_out),
    .whold (cfg_hold),
    .laddr ({state, in}),
    .lentry(lentry),
    .raddr (cfg_raddr),
    .rdata (cfg_rdata),
    .wrej  (wrej)
  );

  assign e = ent_t'(lentry);

  // State/output step, change pulse and sticky write-error flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= STATE_W'(RST_STATE);
      y       <= RST_OUT;
      changed <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (en) begin
        state   <= e.next;
        changed <= (e.next != state);
        if (!e.hold) y <= e.out;
      end else begin
        changed <= 1'b0;
      end
      if (wrej) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_fsm.sv
// Directed bench for prog_fsm: loads the legacy 4-state a/b sequencer and
// exercises hold entries, enable gating, write/step collisions, rejected
// writes and mid-run reset against hand-computed values.
module tb_prog_fsm;
  import prog_fsm_pkg::*;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               en;
  logic [1:0]         in;
  logic [0:0]         y;
  logic [2:0]         state;
  logic               changed;
  logic               cfg_we;
  logic [4:0]         cfg_addr;
  logic [2:0]         cfg_next;
  logic [0:0]         cfg_out;
  logic               cfg_hold;
  logic [4:0]         cfg_raddr;
  logic [4:0]         cfg_rdata;
  logic               cfg_err;

  int checks   = 0;
  int failures = 0;

  prog_fsm dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .en       (en),
    .in       (in),
    .y        (y),
    .state    (state),
    .changed  (changed),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_next (cfg_next),
    .cfg_out  (cfg_out),
    .cfg_hold (cfg_hold),
    .cfg_raddr(cfg_raddr),
    .cfg_rdata(cfg_rdata),
    .cfg_err  (cfg_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_fsm(input string tag, input logic [2:0] s, input logic yv, input logic ch);
    check({tag, ".state"}, 32'(state), 32'(s));
    check({tag, ".y"}, 32'(y), 32'(yv));
    check({tag, ".changed"}, 32'(changed), 32'(ch));
  endtask

  // Single-cycle table write; whatever en/in are set to also steps that cycle.
  task automatic wr(input logic [2:0] s, input logic [1:0] i, input logic [2:0] nx,
                    input logic o, input logic h);
    cfg_we   = 1'b1;
    cfg_addr = pack_addr(s, i);
    cfg_next = nx;
    cfg_out  = o;
    cfg_hold = h;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic rb(input string tag, input logic [2:0] s, input logic [1:0] i, input logic [4:0] exp);
    cfg_raddr = pack_addr(s, i);
    tick();
    check(tag, 32'(cfg_rdata), 32'(exp));
  endtask

  initial begin
    Rst = 1'b1; en = 1'b0; in = 2'b00;
    cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0; cfg_out = '0; cfg_hold = 1'b0; cfg_raddr = '0;

    // Reset state
    tick(); tick();
    expect_fsm("rst", 3'd0, 1'b0, 1'b0);
    check("rst.cfg_err", 32'(cfg_err), 32'd0);
    check("rst.rdata", 32'(cfg_rdata), 32'd0);
    Rst = 1'b0;

    // Unprogrammed machine idles
    en = 1'b1; in = 2'b11;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_fsm("idle", 3'd0, 1'b0, 1'b0);
    end
    check("idle.rdata0", 32'(cfg_rdata), 32'h10);

    // Load the a/b sequencer with stepping disabled
    en = 1'b0;
    wr(3'd0, 2'b01, 3'd1, 1'b1, 1'b0);
    wr(3'd1, 2'b10, 3'd2, 1'b1, 1'b0);
    wr(3'd2, 2'b01, 3'd3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) wr(3'd3, 2'(k), 3'd0, 1'b0, 1'b0);
    wr(3'd1, 2'b00, 3'd1, 1'b0, 1'b1);
    rb("rb.0_01", 3'd0, 2'b01, 5'b00011);
    rb("rb.1_00", 3'd1, 2'b00, 5'b10010);
    check("load.cfg_err", 32'(cfg_err), 32'd0);

    // Sequence in = 01, 10, 01, 00
    en = 1'b1;
    in = 2'b01; tick(); expect_fsm("seq1", 3'd1, 1'b1, 1'b1);
    in = 2'b10; tick(); expect_fsm("seq2", 3'd2, 1'b1, 1'b1);
    in = 2'b01; tick(); expect_fsm("seq3", 3'd3, 1'b0, 1'b1);
    in = 2'b00; tick(); expect_fsm("seq4", 3'd0, 1'b0, 1'b1);

    // Hold entry keeps y=1 in state 1
    in = 2'b01; tick(); expect_fsm("hold0", 3'd1, 1'b1, 1'b1);
    in = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick(); expect_fsm("hold", 3'd1, 1'b1, 1'b0);
    end

    // Enable low freezes the machine regardless of in
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick(); expect_fsm("frozen", 3'd1, 1'b1, 1'b0);
    end
    en = 1'b1;
    in = 2'b10; tick(); expect_fsm("resume1", 3'd2, 1'b1, 1'b1);
    in = 2'b01; tick(); expect_fsm("resume2", 3'd3, 1'b0, 1'b1);
    in = 2'b00; tick(); expect_fsm("resume3", 3'd0, 1'b0, 1'b1);

    // Same-cycle write and step: the step uses the old entry
    in = 2'b01;
    wr(3'd0, 2'b01, 3'd2, 1'b0, 1'b0);
    expect_fsm("rbw.old", 3'd1, 1'b1, 1'b1);
    tick(); expect_fsm("rbw.back", 3'd0, 1'b1, 1'b1);   // (1,01) is a default entry
    tick(); expect_fsm("rbw.new", 3'd2, 1'b0, 1'b1);

    // Rejected writes
    en = 1'b0;
    wr(3'd0, 2'b00, 3'd5, 1'b1, 1'b0);
    check("rej.next.err", 32'(cfg_err), 32'd1);
    rb("rej.next.rb", 3'd0, 2'b00, 5'b10000);
    wr(3'd6, 2'b00, 3'd1, 1'b1, 1'b0);
    rb("rej.state.rb", 3'd6, 2'b00, 5'b10000);
    check("rej.sticky", 32'(cfg_err), 32'd1);

    // Reset mid-run, with a write in the reset cycle that must be discarded
    en = 1'b1; in = 2'b01; tick(); expect_fsm("prerst", 3'd3, 1'b0, 1'b1);
    in = 2'b00; tick(); expect_fsm("prerst2", 3'd0, 1'b0, 1'b1);
    in = 2'b01; tick(); expect_fsm("prerst3", 3'd2, 1'b0, 1'b1);
    Rst = 1'b1;
    wr(3'd0, 2'b10, 3'd1, 1'b1, 1'b0);
    Rst = 1'b0;
    expect_fsm("midrst", 3'd0, 1'b0, 1'b0);
    check("midrst.cfg_err", 32'(cfg_err), 32'd0);
    en = 1'b0;
    rb("midrst.rb0_01", 3'd0, 2'b01, 5'b10000);
    rb("midrst.rb0_10", 3'd0, 2'b10, 5'b10000);
    rb("midrst.rb3_00", 3'd3, 2'b00, 5'b10000);
    en = 1'b1; in = 2'b01;
    tick(); expect_fsm("midrst.idle", 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_fsm.md
Name: prog_fsm

Overview:
- Table-driven, programmable finite-state machine. It replaces the team's hand-coded small controllers, such as the 4-state a/b sequencers with a registered y output.
- State count, input width and output width are parameters.
- Transitions and outputs live in a run-time writable table. One entry per {state, input} pair holds next state, output value and an output-hold flag.
- Sits between datapath status inputs and control outputs. A config master loads the table.

Parameters:
- IN_W, 2, width of the input vector `in` (bit1 = a, bit0 = b in legacy use)
- STATE_W, 3, state register width
- OUT_W, 1, width of output `y`
- NUM_STATES, 4, number of legal states; must satisfy 2 ≤ NUM_STATES ≤ 2^STATE_W
- RST_STATE, 0, state after reset; must be < NUM_STATES
- RST_OUT, 0, value of `y` after reset

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  synchronous reset, active-high
- en  in  1  step enable
- in  in  IN_W  FSM input vector
- y  out  OUT_W  registered FSM output
- state  out  STATE_W  current state
- changed  out  1  one-cycle pulse: last step moved to a different state
- cfg_we  in  1  table write strobe
- cfg_addr  in  STATE_W+IN_W  entry address = {state, in}
- cfg_next  in  STATE_W  next state for the entry
- cfg_out  in  OUT_W  output value for the entry
- cfg_hold  in  1  1 = entry leaves y unchanged
- cfg_raddr  in  STATE_W+IN_W  readback address
- cfg_rdata  out  STATE_W+OUT_W+1  registered readback {hold, next, out}
- cfg_err  out  1  sticky: a write was rejected

Behaviour:
- Rst is synchronous and active-high on Clk. It has priority over en and cfg_we; a write in a reset cycle is discarded.
- Reset values:
  - state = RST_STATE
  - y = RST_OUT
  - changed = 0
  - cfg_err = 0
  - cfg_rdata = 0
  - every table entry = {hold=1, next=RST_STATE, out=0}, so an unprogrammed machine idles.
- Table is flop-based with 2^(STATE_W+IN_W) entries, fully reset.
- Step, when en=1 and Rst=0:
  - lookup address = {state, in}, entry E
  - state <= E.next
  - y <= E.out if E.hold=0; otherwise y is held
  - changed <= (E.next != state)
  - y and state take their new values one edge after `in` is sampled, as in a registered Mealy machine.
- When en=0: state and y hold, changed <= 0, and `in` is ignored.
- Write, when cfg_we=1 and Rst=0, with entry state field = cfg_addr[STATE_W+IN_W-1:IN_W]:
  - Rejected if the entry state field ≥ NUM_STATES, or if cfg_next ≥ NUM_STATES.
  - On rejection the table is unchanged and cfg_err <= 1. cfg_err clears only on Rst.
  - Otherwise the entry is written at the edge.
- Write and step in the same cycle to the same address: the step uses the OLD entry (read-before-write). The new entry applies from the next lookup.
- Readback: cfg_rdata <= table[cfg_raddr] every cycle, 1-cycle latency. It shows the pre-write value if a write to the same address happens in the same cycle.
- Illegal states: because writes are validated, state never leaves 0..NUM_STATES-1. Any entry whose state field ≥ NUM_STATES is unreachable and reads back its reset value.
- Reset mid-run: the table returns to defaults, so the config master must reload it.

Decomposition:
- Shared package prog_fsm_pkg contains:
  - localparams ADDR_W = STATE_W+IN_W and ENTRY_W = STATE_W+OUT_W+1
  - entry typedef {hold, next, out}
  - default-entry constant
  - address-pack function {state, in}
- One sub-module, prog_fsm_table: flop array with reset, validated write port, combinational lookup port and registered readback port.
- The top level holds the state/y registers, the changed logic and cfg_err.

Test Plan:
- Reset, then en=1 with in=2'b11 for 5 cycles → state=0, y=0, changed=0 throughout; cfg_rdata at addr 0 = {1,0,0}.
- Load a 4-state a/b sequence:
  - entries (0,01) → {0,1,1}, (1,10) → {0,2,1}, (2,01) → {0,3,0}, (3,xx) → {0,0,0}
  - drive in = 01, 10, 01, 00
  - → state 1, 2, 3, 0 on successive edges; y = 1, 1, 0, 0; changed=1 each step.
- Hold entry (1,00) → {1,1,0} with y=1 and in=00 for 3 cycles → y stays 1, state stays 1, changed=0.
- en=0 for 4 cycles with in toggling → state and y frozen, changed=0. Re-assert en → stepping resumes from the frozen state.
- Same-cycle write and step: in state 0 with in=01, write (0,01) → {0,2,0} → the step goes to state 1 (old entry). Returning to 0 and repeating in=01 goes to state 2.
- Write cfg_next=5 (NUM_STATES=4), then a separate write with cfg_addr state field = 6 → cfg_err=1 and entries unchanged on readback. Rst during a stepping sequence → state=0, y=0, cfg_err=0, all entries back to default.
